rx_ack_gen: RTL and testbench



---
 rtl/rx_ack_gen.sv | 163 ++++++++++++++++
 tb/tb_rx_ack_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ack_gen.sv
// Receive-side ACK/NAK generator: tracks ePSN for one connection, coalesces
// in-order packets into cumulative ACKs, re-ACKs duplicates and NAKs each gap once.
module rx_ack_gen #(
  parameter int                   WQE_INDEX_WIDTH = 10,
  parameter int                   PSN_WIDTH       = 24,
  parameter logic [PSN_WIDTH-1:0] INIT_PSN        = '0,
  parameter int                   ACK_COALESCE    = 8,
  parameter int                   ACK_TIMEOUT     = 1000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       s_axis_rx_valid,
  input  logic [WQE_INDEX_WIDTH-1:0] s_axis_rx_id,
  input  logic [PSN_WIDTH-1:0]       s_axis_rx_psn,
  input  logic                       s_axis_rx_last,
  output logic                       s_axis_rx_ready,
  output logic                       m_axis_ack_valid,
  output logic [WQE_INDEX_WIDTH-1:0] m_axis_ack_id,
  output logic [PSN_WIDTH-1:0]       m_axis_ack_psn,
  output logic                       m_axis_ack_nak,
  input  logic                       m_axis_ack_ready,
  output logic [PSN_WIDTH-1:0]       rx_epsn
);

  localparam int CNT_W = $clog2(ACK_COALESCE + 1);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_NAK  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ACK_COALESCE - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_PRE   = TMR_W'(ACK_TIMEOUT - 1);

  logic [1:0]                 state_q,     state_d;
  logic [PSN_WIDTH-1:0]       epsn_q,      epsn_d;
  logic [WQE_INDEX_WIDTH-1:0] last_id_q,   last_id_d;
  logic [CNT_W-1:0]           cnt_q,       cnt_d;
  logic [TMR_W-1:0]           timer_q,     timer_d;
  logic                       ack_valid_q, ack_valid_d;
  logic [WQE_INDEX_WIDTH-1:0] ack_id_q,    ack_id_d;
  logic [PSN_WIDTH-1:0]       ack_psn_q,   ack_psn_d;
  logic                       ack_nak_q,   ack_nak_d;

  logic                 accept;
  logic [PSN_WIDTH-1:0] diff;
  logic [PSN_WIDTH-1:0] epsn_m1;
  logic                 is_inorder;
  logic                 is_gap;
  logic                 flush_inorder;
  logic                 timeout_fire;

  assign accept     = s_axis_rx_valid & ~ack_valid_q;
  assign diff       = s_axis_rx_psn - epsn_q;
  assign epsn_m1    = epsn_q - 1'b1;
  assign is_inorder = (diff == '0);
  // Forward distance below half the PSN space is a gap; the upper half is old.
  assign is_gap     = ~is_inorder & ~diff[PSN_WIDTH-1];

  // cnt_q is zero outside PEND, so the coalesce test needs no state qualifier.
  assign flush_inorder = (cnt_q == CNT_LAST) | s_axis_rx_last |
                         ((state_q == ST_PEND) & (timer_q == TMR_PRE));
  assign timeout_fire  = (state_q == ST_PEND) & (timer_q == TMR_LIMIT) & ~ack_valid_q;

  always_comb begin
    state_d     = state_q;
    epsn_d      = epsn_q;
    last_id_d   = last_id_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    ack_valid_d = ack_valid_q & ~m_axis_ack_ready;
    ack_id_d    = ack_id_q;
    ack_psn_d   = ack_psn_q;
    ack_nak_d   = ack_nak_q;

    if ((state_q == ST_PEND) && (timer_q != TMR_LIMIT)) begin
      timer_d = timer_q + 1'b1;
    end

    if (accept) begin
      if (is_inorder) begin
        epsn_d    = epsn_q + 1'b1;
        last_id_d = s_axis_rx_id;
        if (flush_inorder) begin
          ack_valid_d = 1'b1;
          ack_id_d    = s_axis_rx_id;
          ack_psn_d   = s_axis_rx_psn;
          ack_nak_d   = 1'b0;
          cnt_d       = '0;
          timer_d     = '0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_PEND;
          if (state_q != ST_PEND) begin
            timer_d = '0;
          end
        end
      end else if (is_gap) begin
        cnt_d   = '0;
        timer_d = '0;
        if (state_q != ST_NAK) begin
          ack_valid_d = 1'b1;
          ack_id_d    = last_id_q;
          ack_psn_d   = epsn_q;
          ack_nak_d   = 1'b1;
          state_d     = ST_NAK;
        end
      end else begin
        ack_valid_d = 1'b1;
        ack_id_d    = last_id_q;
        ack_psn_d   = epsn_m1;
        ack_nak_d   = 1'b0;
        cnt_d       = '0;
        timer_d     = '0;
        if (state_q != ST_NAK) begin
          state_d = ST_IDLE;
        end
      end
    end else if (timeout_fire) begin
      ack_valid_d = 1'b1;
      ack_id_d    = last_id_q;
      ack_psn_d   = epsn_m1;
      ack_nak_d   = 1'b0;
      cnt_d       = '0;
      timer_d     = '0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      epsn_q      <= INIT_PSN;
      last_id_q   <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      ack_valid_q <= 1'b0;
      ack_id_q    <= '0;
      ack_psn_q   <= '0;
      ack_nak_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      epsn_q      <= epsn_d;
      last_id_q   <= last_id_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      ack_valid_q <= ack_valid_d;
      ack_id_q    <= ack_id_d;
      ack_psn_q   <= ack_psn_d;
      ack_nak_q   <= ack_nak_d;
    end
  end

  assign s_axis_rx_ready  = ~ack_valid_q;
  assign m_axis_ack_valid = ack_valid_q;
  assign m_axis_ack_id    = ack_id_q;
  assign m_axis_ack_psn   = ack_psn_q;
  assign m_axis_ack_nak   = ack_nak_q;
  assign rx_epsn          = epsn_q;

endmodule

// File: tb/tb_rx_ack_gen.sv
// Bench for rx_ack_gen: directed scenarios plus random traffic against a
// packet-level reference model; a second instance covers PSN wrap-around.
module tb_rx_ack_gen;

  localparam int T = 50;
  localparam int C = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (INIT_PSN = 0)
  logic        rst, rx_valid, rx_last, rx_ready, ack_valid, ack_nak, ack_ready;
  logic [9:0]  rx_id, ack_id;
  logic [23:0] rx_psn, ack_psn, epsn;

  // Wrap instance (INIT_PSN = 0xFFFFFE)
  logic        rst_b, rx_valid_b, rx_ready_b, ack_valid_b, ack_nak_b;
  logic [9:0]  rx_id_b, ack_id_b;
  logic [23:0] rx_psn_b, ack_psn_b, epsn_b;

  rx_ack_gen #(.WQE_INDEX_WIDTH(10), .PSN_WIDTH(24), .INIT_PSN(24'h000000),
               .ACK_COALESCE(C), .ACK_TIMEOUT(T)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .s_axis_rx_valid(rx_valid), .s_axis_rx_id(rx_id), .s_axis_rx_psn(rx_psn),
    .s_axis_rx_last(rx_last), .s_axis_rx_ready(rx_ready),
    .m_axis_ack_valid(ack_valid), .m_axis_ack_id(ack_id), .m_axis_ack_psn(ack_psn),
    .m_axis_ack_nak(ack_nak), .m_axis_ack_ready(ack_ready), .rx_epsn(epsn));

  rx_ack_gen #(.WQE_INDEX_WIDTH(10), .PSN_WIDTH(24), .INIT_PSN(24'hFFFFFE),
               .ACK_COALESCE(8), .ACK_TIMEOUT(1000)) dut_wrap (
    .sys_clk(clk), .sys_rst(rst_b),
    .s_axis_rx_valid(rx_valid_b), .s_axis_rx_id(rx_id_b), .s_axis_rx_psn(rx_psn_b),
    .s_axis_rx_last(1'b0), .s_axis_rx_ready(rx_ready_b),
    .m_axis_ack_valid(ack_valid_b), .m_axis_ack_id(ack_id_b), .m_axis_ack_psn(ack_psn_b),
    .m_axis_ack_nak(ack_nak_b), .m_axis_ack_ready(1'b1), .rx_epsn(epsn_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: packets received but not yet acknowledged, age of the
  // oldest unacknowledged packet, gap-outstanding flag, and the expected output.
  logic [23:0] m_epsn;
  logic [9:0]  m_last;
  int          m_unacked;
  int          m_age;
  bit          m_gap;
  bit          e_valid;
  logic [9:0]  e_id;
  logic [23:0] e_psn;
  bit          e_nak;

  task automatic model_reset();
    m_epsn = 24'h0; m_last = '0; m_unacked = 0; m_age = 0; m_gap = 0;
    e_valid = 0; e_id = '0; e_psn = '0; e_nak = 0;
  endtask

  task automatic emit(input logic [23:0] p, input logic [9:0] i, input bit n);
    e_valid = 1; e_psn = p; e_id = i; e_nak = n;
  endtask

  task automatic model(input bit v, input logic [9:0] id, input logic [23:0] psn,
                       input bit last, input bit ardy, output bit acc);
    bit          was_valid;
    int          age_next;
    logic [23:0] d;
    was_valid = e_valid;
    acc       = v && !was_valid;
    age_next  = (m_unacked > 0) ? ((m_age < T) ? m_age + 1 : T) : 0;
    if (was_valid && ardy) e_valid = 0;
    if (acc) begin
      d = psn - m_epsn;
      if (d == 24'h0) begin
        if (m_unacked + 1 == C || last || (m_unacked > 0 && m_age == T - 1)) begin
          emit(psn, id, 0);
          m_unacked = 0; m_age = 0;
        end else begin
          m_age = age_next;
          m_unacked++;
        end
        m_epsn = m_epsn + 24'h1;
        m_last = id;
        m_gap  = 0;
      end else if (d < 24'h800000) begin
        if (!m_gap) emit(m_epsn, m_last, 1);
        m_gap = 1; m_unacked = 0; m_age = 0;
      end else begin
        emit(m_epsn - 24'h1, m_last, 0);
        m_unacked = 0; m_age = 0;
      end
    end else if (m_unacked > 0 && m_age >= T && !was_valid) begin
      emit(m_epsn - 24'h1, m_last, 0);
      m_unacked = 0; m_age = 0;
    end else begin
      m_age = age_next;
    end
  endtask

  task automatic compare();
    chk("ready", rx_ready, !e_valid);
    chk("valid", ack_valid, e_valid);
    chk("epsn", epsn, m_epsn);
    if (e_valid) begin
      chk("ack_psn", ack_psn, e_psn);
      chk("ack_id", ack_id, e_id);
      chk("ack_nak", ack_nak, e_nak);
    end
  endtask

  task automatic step(input bit v, input logic [9:0] id, input logic [23:0] psn,
                      input bit last, input bit ardy, output bit acc);
    rx_valid = v; rx_id = id; rx_psn = psn; rx_last = last; ack_ready = ardy;
    model(v, id, psn, last, ardy, acc);
    @(posedge clk); #1;
    compare();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 1, acc);
  endtask

  task automatic send(input logic [23:0] psn, input logic [9:0] id, input bit last);
    bit acc;
    int guard;
    acc = 0; guard = 0;
    while (!acc && guard < 20) begin
      step(1, id, psn, last, 1, acc);
      guard++;
    end
    if (!acc) chk("send_accept_bound", 0, 1);
    rx_valid = 0;
  endtask

  task automatic reset_main();
    rst = 1; rx_valid = 0; rx_last = 0; ack_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    chk("rst_valid", ack_valid, 0);
    chk("rst_id", ack_id, 0);
    chk("rst_psn", ack_psn, 0);
    chk("rst_nak", ack_nak, 0);
    chk("rst_epsn", epsn, 0);
    chk("rst_ready", rx_ready, 1);
  endtask

  task automatic cyc_b();
    @(posedge clk); #1;
  endtask

  logic [9:0] ids [8];
  int         k;
  int         quiet;
  bit         acc;
  logic [23:0] psn_r;
  int          off, r;

  initial begin
    rst = 1; rx_valid = 0; rx_id = '0; rx_psn = '0; rx_last = 0; ack_ready = 1;
    rst_b = 1; rx_valid_b = 0; rx_id_b = '0; rx_psn_b = '0;

    // PSN wrap on the second instance
    cyc_b(); cyc_b();
    rst_b = 0;
    chk("W_rst_epsn", epsn_b, 24'hFFFFFE);
    chk("W_rst_valid", ack_valid_b, 0);
    rx_valid_b = 1; rx_psn_b = 24'hFFFFFE; rx_id_b = 10'h011; cyc_b();
    rx_psn_b = 24'hFFFFFF; rx_id_b = 10'h012; cyc_b();
    rx_psn_b = 24'h000000; rx_id_b = 10'h013; cyc_b();
    rx_valid_b = 0;
    chk("W_epsn", epsn_b, 24'h000001);
    chk("W_no_ack", ack_valid_b, 0);
    rx_valid_b = 1; rx_psn_b = 24'h800001; rx_id_b = 10'h014; cyc_b();
    rx_valid_b = 0;
    chk("W_dup_valid", ack_valid_b, 1);
    chk("W_dup_nak", ack_nak_b, 0);
    chk("W_dup_psn", ack_psn_b, 24'h000000);
    chk("W_dup_id", ack_id_b, 10'h013);
    chk("W_dup_epsn", epsn_b, 24'h000001);

    // Eight in-order packets coalesce into one ACK
    reset_main();
    for (int i = 0; i < 8; i++) begin
      ids[i] = 10'($urandom_range(0, 1023));
      send(24'(i), ids[i], 0);
    end
    chk("A_valid", ack_valid, 1);
    chk("A_psn", ack_psn, 7);
    chk("A_nak", ack_nak, 0);
    chk("A_id", ack_id, ids[7]);
    chk("A_epsn", epsn, 8);
    idle(3);

    // last forces an immediate ACK; then nothing more for 2000 cycles
    reset_main();
    send(24'd0, 10'd5, 0);
    send(24'd1, 10'd6, 0);
    send(24'd2, 10'd7, 1);
    chk("B_valid", ack_valid, 1);
    chk("B_psn", ack_psn, 2);
    chk("B_id", ack_id, 7);
    idle(1);
    quiet = 0;
    for (int i = 0; i < 2000; i++) begin
      step(0, '0, '0, 0, 1, acc);
      if (ack_valid) quiet++;
    end
    chk("B_quiet", quiet, 0);

    // Timeout ACK exactly T cycles after the last accept
    reset_main();
    send(24'd0, 10'd1, 0);
    send(24'd1, 10'd2, 0);
    k = 0;
    while (!ack_valid && k < 200) begin
      step(0, '0, '0, 0, 1, acc);
      k++;
    end
    chk("C_latency", k, T);
    chk("C_psn", ack_psn, 1);
    chk("C_nak", ack_nak, 0);
    chk("C_id", ack_id, 2);
    idle(2);

    // Gap: one NAK, further out-of-order dropped, fill resumes
    reset_main();
    send(24'd0, 10'd20, 0);
    send(24'd1, 10'd21, 0);
    send(24'd3, 10'd23, 0);
    chk("D_nak_valid", ack_valid, 1);
    chk("D_nak", ack_nak, 1);
    chk("D_nak_psn", ack_psn, 2);
    chk("D_nak_id", ack_id, 21);
    send(24'd4, 10'd24, 0);
    send(24'd5, 10'd25, 0);
    chk("D_dropped", ack_valid, 0);
    chk("D_epsn_hold", epsn, 2);
    send(24'd2, 10'd22, 0);
    chk("D_fill_epsn", epsn, 3);
    chk("D_fill_quiet", ack_valid, 0);
    idle(T + 5);

    // Duplicate re-ACK with the sink stalled
    reset_main();
    for (int i = 0; i < 5; i++) send(24'(i), 10'(40 + i), 0);
    step(1, 10'd99, 24'd3, 0, 0, acc);
    chk("E_valid", ack_valid, 1);
    chk("E_psn", ack_psn, 4);
    chk("E_id", ack_id, 44);
    chk("E_nak", ack_nak, 0);
    chk("E_epsn", epsn, 5);
    for (int i = 0; i < 4; i++) begin
      step(1, 10'd55, 24'd5, 0, 0, acc);
      chk("E_stall_ready", rx_ready, 0);
      chk("E_stall_psn", ack_psn, 4);
    end
    idle(3);

    // Random traffic against the model
    reset_main();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      off = 0;
      else if (r < 75) off = -$urandom_range(1, 3);
      else if (r < 92) off = $urandom_range(1, 3);
      else             off = $urandom;
      psn_r = m_epsn + 24'(off);
      step(($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)), psn_r,
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), acc);
    end
    idle(T + 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
